// File: rtl/nserial_pkg.sv
// Shared definitions for the Nintendo-style 1-wire serial receive path:
// decoder state encoding and default pulse timing in clk cycles (6 MHz).
package nserial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        ERR  = 2'd3
    } rx_state_t;

    localparam int NSERIAL_LOW_THRESH   = 12;
    localparam int NSERIAL_LOW_MAX      = 30;
    localparam int NSERIAL_IDLE_TIMEOUT = 30;
    localparam int NSERIAL_BIT_CLKS     = 24;

endpackage

// File: rtl/nserial_rx_sync.sv
// Line synchroniser with edge detect for the 1-wire receiver.
// Optional: NSERIAL_RX_GLITCH_FILTER_EN adds a two-equal-sample level filter.
module nserial_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic level,
    output logic fall,
    output logic rise
);
    logic [1:0] sync_reg;
    logic       prev_reg;
    logic       level_w;

    // The idle bus is released (high), so every stage resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

`ifdef NSERIAL_RX_GLITCH_FILTER_EN
    logic stage_reg;
    logic filt_reg;

    // The filtered level only moves once two successive samples agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_reg <= 1'b1;
            filt_reg  <= 1'b1;
        end else begin
            stage_reg <= sync_reg[1];
            if (stage_reg == sync_reg[1]) begin
                filt_reg <= sync_reg[1];
            end
        end
    end

    assign level_w = filt_reg;
`else
    assign level_w = sync_reg[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= level_w;
        end
    end

    assign level = level_w;
    assign fall  = prev_reg & ~level_w;
    assign rise  = ~prev_reg & level_w;

endmodule

// File: rtl/nserial_rx_decoder.sv
// Receive-side pulse-width decoder for one controller port of the 1-wire bus.
// Optional: NSERIAL_RX_GLITCH_FILTER_EN (filter inside nserial_rx_sync).
module nserial_rx_decoder
    import nserial_pkg::*;
#(
    parameter int LOW_THRESH   = NSERIAL_LOW_THRESH,
    parameter int LOW_MAX      = NSERIAL_LOW_MAX,
    parameter int IDLE_TIMEOUT = NSERIAL_IDLE_TIMEOUT,
    parameter int CNT_W        = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_start,
    output logic rx_stop,
    output logic rx_error,
    output logic rx_data,
    output logic rx_strobe
);
    localparam logic [CNT_W-1:0] THRESH_CNT  = CNT_W'(LOW_THRESH);
    localparam logic [CNT_W-1:0] LOW_MAX_CNT = CNT_W'(LOW_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    logic line_level;
    logic line_fall;
    logic line_rise;

    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             pending_reg, pending_next;
    logic             pending_valid_reg, pending_valid_next;
    logic             start_reg, start_next;
    logic             stop_reg, stop_next;
    logic             error_reg, error_next;
    logic             data_reg, data_next;
    logic             strobe_reg, strobe_next;

    nserial_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .level (line_level),
        .fall  (line_fall),
        .rise  (line_rise)
    );

    // cnt_inc is the value the counter reaches at this edge; the fall sample
    // itself is not counted, so at a rise cnt_inc equals the low length.
    assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_inc;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        start_next         = 1'b0;
        stop_next          = 1'b0;
        error_next         = 1'b0;
        data_next          = 1'b0;
        strobe_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (line_fall) begin
                    start_next         = 1'b1;
                    pending_valid_next = 1'b0;
                    state_next         = LOW;
                end
            end
            LOW: begin
                if (line_rise) begin
                    pending_next       = (cnt_inc < THRESH_CNT);
                    pending_valid_next = 1'b1;
                    state_next         = HIGH;
                end else if (cnt_inc == LOW_MAX_CNT) begin
                    error_next = 1'b1;
                    state_next = ERR;
                end
            end
            HIGH: begin
                // Timeout has priority: a fall landing on the timeout cycle is dropped.
                if (cnt_inc == TIMEOUT_CNT) begin
                    stop_next  = pending_reg;
                    error_next = ~pending_reg;
                    state_next = IDLE;
                end else if (line_fall) begin
                    strobe_next = pending_valid_reg;
                    data_next   = pending_valid_reg & pending_reg;
                    state_next  = LOW;
                end
            end
            ERR: begin
                if (line_level) begin
                    if (cnt_inc == TIMEOUT_CNT) begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            pending_reg       <= 1'b0;
            pending_valid_reg <= 1'b0;
            start_reg         <= 1'b0;
            stop_reg          <= 1'b0;
            error_reg         <= 1'b0;
            data_reg          <= 1'b0;
            strobe_reg        <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            start_reg         <= start_next;
            stop_reg          <= stop_next;
            error_reg         <= error_next;
            data_reg          <= data_next;
            strobe_reg        <= strobe_next;
        end
    end

    assign rx_start  = start_reg;
    assign rx_stop   = stop_reg;
    assign rx_error  = error_reg;
    assign rx_data   = data_reg;
    assign rx_strobe = strobe_reg;

endmodule

// File: tb/tb_nserial_rx_decoder.sv
// Bench for nserial_rx_decoder: frame table plus corner sequences, with a
// scoreboard of expected output pulses (kind, data, cycle).
`timescale 1ns/1ps
module tb_nserial_rx_decoder;
    import nserial_pkg::*;

    localparam int BIT_CLKS  = NSERIAL_BIT_CLKS;
    localparam int SHORT_LOW = 6;
    localparam int LONG_LOW  = 18;
    localparam int TIMEOUT   = 30;
    localparam int LOW_LIMIT = 30;
`ifdef NSERIAL_RX_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef enum int {EV_START, EV_STROBE, EV_STOP, EV_ERROR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        logic     data;
        int       cyc;
    } ev_t;
    typedef struct {
        string       name;
        logic [31:0] data;
        int          nbits;
        int          one_low;
        int          zero_low;
        int          stop_low;
        bit          exp_stop;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic rx_start, rx_stop, rx_error, rx_data, rx_strobe;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    ev_t   exp_q[$];
    string cur_name = "reset";

    nserial_rx_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_start  (rx_start),
        .rx_stop   (rx_stop),
        .rx_error  (rx_error),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] kind_vec(input ev_kind_t k);
        case (k)
            EV_START:  return 4'b1000;
            EV_STROBE: return 4'b0100;
            EV_STOP:   return 4'b0010;
            default:   return 4'b0001;
        endcase
    endfunction

    // Outputs {start,strobe,stop,error} sampled on the falling edge.
    always @(negedge clk) begin
        logic [3:0] obs;
        ev_t        ev;
        obs = {rx_start, rx_strobe, rx_stop, rx_error};
        if (obs !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected: start/strobe/stop/error=%b data=%b at cycle %0d, required no output",
                         cur_name, obs, rx_data, cyc);
            end else begin
                ev = exp_q.pop_front();
                if (obs !== kind_vec(ev.kind) || cyc != ev.cyc ||
                    (ev.kind == EV_STROBE && rx_data !== ev.data)) begin
                    errors++;
                    $display("FAIL %s %s: got outputs=%b data=%b cycle=%0d, required outputs=%b data=%b cycle=%0d",
                             cur_name, ev.kind.name(), obs, rx_data, cyc, kind_vec(ev.kind), ev.data, ev.cyc);
                end else begin
                    $display("ok   %s %s data=%b cycle=%0d", cur_name, ev.kind.name(), rx_data, cyc);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing %s: got no output by cycle %0d, required at cycle %0d data=%b",
                     cur_name, ev.kind.name(), cyc, ev.cyc, ev.data);
        end
    end

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic d, input int at);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_outs(input string what, input logic [4:0] want);
        logic [4:0] got;
        got = {rx_start, rx_strobe, rx_stop, rx_error, rx_data};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: start/strobe/stop/error/data got %b, required %b", what, got, want);
        end else begin
            $display("ok   %s outputs=%b", what, got);
        end
    endtask

    // Drives a whole frame MSB-first and queues the pulses it should produce.
    task automatic send_frame(input logic [31:0] data, input int nbits, input int one_low,
                              input int zero_low, input int stop_low, input bit exp_stop);
        logic prev_bit;
        logic b;
        int   low;
        prev_bit = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            b = data[nbits-1-i];
            if (i == 0) expect_ev(EV_START, 1'b0, cyc + LAT);
            else        expect_ev(EV_STROBE, prev_bit, cyc + LAT);
            low = b ? one_low : zero_low;
            hold(1'b0, low);
            hold(1'b1, BIT_CLKS - low);
            prev_bit = b;
        end
        if (nbits == 0) expect_ev(EV_START, 1'b0, cyc + LAT);
        else            expect_ev(EV_STROBE, prev_bit, cyc + LAT);
        hold(1'b0, stop_low);
        expect_ev(exp_stop ? EV_STOP : EV_ERROR, 1'b0, cyc + TIMEOUT + LAT);
        hold(1'b1, TIMEOUT + LAT + 10);
    endtask

    function automatic vec_t mk_vec(input string n, input logic [31:0] d, input int nb,
                                    input int ol, input int zl, input int sl, input bit es);
        vec_t v;
        v.name = n;  v.data = d;      v.nbits = nb;
        v.one_low = ol; v.zero_low = zl; v.stop_low = sl; v.exp_stop = es;
        return v;
    endfunction

    initial begin
        vec_t vecs[7];
        int   wait_cnt;
        vecs[0] = mk_vec("id_req_0x00",    32'h00,     8,  SHORT_LOW, LONG_LOW, SHORT_LOW, 1'b1);
        vecs[1] = mk_vec("status_400301",  32'h400301, 24, SHORT_LOW, LONG_LOW, SHORT_LOW, 1'b1);
        vecs[2] = mk_vec("thresh_11_then_12", 32'h2,   2,  11,        12,       SHORT_LOW, 1'b1);
        vecs[3] = mk_vec("thresh_12_then_11", 32'h1,   2,  11,        12,       SHORT_LOW, 1'b1);
        vecs[4] = mk_vec("degenerate",     32'h0,      0,  SHORT_LOW, LONG_LOW, SHORT_LOW, 1'b1);
        vecs[5] = mk_vec("bad_stop_0x00",  32'h00,     8,  SHORT_LOW, LONG_LOW, LONG_LOW,  1'b0);
        vecs[6] = mk_vec("frame_0xa5",     32'hA5,     8,  SHORT_LOW, LONG_LOW, SHORT_LOW, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_state", 5'b00000);
        reset = 1'b0;
        hold(1'b1, 8);

        foreach (vecs[i]) begin
            cur_name = vecs[i].name;
            send_frame(vecs[i].data, vecs[i].nbits, vecs[i].one_low, vecs[i].zero_low,
                       vecs[i].stop_low, vecs[i].exp_stop);
        end

        // Line stuck low: error after the low limit, then 30 high clocks re-arm.
        cur_name = "low_40";
        expect_ev(EV_START, 1'b0, cyc + LAT);
        expect_ev(EV_ERROR, 1'b0, cyc + LOW_LIMIT + LAT);
        hold(1'b0, 40);
        hold(1'b1, 30);
        cur_name = "after_err_0x41";
        send_frame(32'h41, 8, SHORT_LOW, LONG_LOW, SHORT_LOW, 1'b1);

        // Fall coinciding with the idle timeout is lost; the next fall starts a frame.
        cur_name = "timeout_tie";
        expect_ev(EV_START, 1'b0, cyc + LAT);
        hold(1'b0, SHORT_LOW);
        expect_ev(EV_STOP, 1'b0, cyc + TIMEOUT + LAT);
        hold(1'b1, TIMEOUT);
        hold(1'b0, SHORT_LOW);
        hold(1'b1, LONG_LOW);
        cur_name = "after_tie";
        expect_ev(EV_START, 1'b0, cyc + LAT);
        hold(1'b0, SHORT_LOW);
        expect_ev(EV_STOP, 1'b0, cyc + TIMEOUT + LAT);
        hold(1'b1, TIMEOUT + LAT + 10);

        // Reset during the strobe of bit 2 of a frame.
        cur_name = "reset_mid";
        expect_ev(EV_START, 1'b0, cyc + LAT);
        hold(1'b0, LONG_LOW);
        hold(1'b1, BIT_CLKS - LONG_LOW);
        for (int i = 0; i < 2; i++) begin
            expect_ev(EV_STROBE, 1'b0, cyc + LAT);
            hold(1'b0, LONG_LOW);
            hold(1'b1, BIT_CLKS - LONG_LOW);
        end
        rx = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        check_outs("strobe_before_reset", 5'b01000);
        reset = 1'b1;
        exp_q.delete();
        rx = 1'b1;
        #1;
        check_outs("reset_mid_frame", 5'b00000);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        hold(1'b1, 10);
        cur_name = "after_reset";
        send_frame(32'h1, 1, SHORT_LOW, LONG_LOW, SHORT_LOW, 1'b1);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 200) begin
            @(posedge clk);
            wait_cnt++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected pulses outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nserial_rx_decoder.md
Name: nserial_rx_decoder

Overview:
- Receive-side line decoder for the Nintendo-style 1-wire serial bus, one instance per controller port.
- Sits between the port's I/O buffer receive output and the controller emulator state machine.
- Measures low/high pulse widths on the synchronised line and emits per-bit strobes, frame start, stop-bit detection and error pulses.
- Holds each decoded bit until the next falling edge confirms it is data rather than the stop bit, so consumers count exactly the data bits.

Parameters:
LOW_THRESH, 12, low-time threshold in clk cycles (~2 us @ 6 MHz); low length < LOW_THRESH decodes 1, >= decodes 0
LOW_MAX, 30, low-time limit in clk cycles; reaching it is a line error
IDLE_TIMEOUT, 30, high-time in clk cycles that ends a frame
CNT_W, 6, pulse counter width; must hold max(LOW_MAX, IDLE_TIMEOUT)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
rx  in  1  raw line level from I/O buffer (1 = released/high)
rx_start  out  1  one-cycle pulse: first falling edge after idle
rx_stop  out  1  one-cycle pulse: valid stop bit followed by idle
rx_error  out  1  one-cycle pulse: low too long, or stop bit decoded as 0
rx_data  out  1  decoded bit; valid only while rx_strobe is high
rx_strobe  out  1  one-cycle pulse per confirmed data bit

Behaviour:
- Reset: all outputs 0; state IDLE; synchroniser flops reset to 1; counter 0; pending_valid 0. Reset mid-frame discards the frame with no stop or error pulse.
- Sync: 2-flop synchroniser, then a previous-sample register; fall = prev & ~cur, rise = ~prev & cur.
- Output latency: all outputs are registered. An output pulse appears 1 clk after the sync-domain edge that causes it, i.e. 3 clks after the rx pin edge.
- Counter: saturating at its maximum value; cleared on every state change.
- IDLE:
  - On fall: pulse rx_start, clear pending_valid, go to LOW.
- LOW (counter counts low cycles):
  - On rise: pending = (cnt < LOW_THRESH); set pending_valid; go to HIGH.
  - If cnt reaches LOW_MAX with the line still low: pulse rx_error, go to ERR.
- HIGH (counter counts high cycles):
  - On fall: if pending_valid, pulse rx_strobe with rx_data = pending; go to LOW.
  - If cnt reaches IDLE_TIMEOUT: if pending == 1, pulse rx_stop, else pulse rx_error; go to IDLE.
- ERR:
  - The counter counts consecutive high cycles and clears on any low sample.
  - Reaching IDLE_TIMEOUT returns to IDLE. No outputs are generated while in ERR.
- Frame of N data bits gives: 1 rx_start, N rx_strobe, then exactly one of rx_stop or rx_error.
- Degenerate frame (a single pulse only): rx_start then rx_stop, no strobes.
- rx_start and the first strobe can never coincide; a strobe and rx_stop can never coincide.
- A fall in the same cycle that IDLE_TIMEOUT is reached: the timeout wins. The fall is lost and the next frame starts at its following fall.

Optional Feature:
NSERIAL_RX_GLITCH_FILTER_EN:
- Defined: the synchronised level is accepted only after 2 consecutive equal samples; a single-cycle glitch is ignored. Edge-to-output latency becomes 5 clks; pulse widths are measured on the filtered signal.
- Undefined: no filter; latency is 3 clks.

Decomposition:
- Shared package nserial_pkg:
  - state encoding: IDLE, LOW, HIGH, ERR
  - default timing constants: LOW_THRESH, LOW_MAX, IDLE_TIMEOUT
  - bit-period constant: 24 clks
- Sub-module nserial_rx_sync: synchroniser, optional glitch filter, rise/fall detect.
- Top module: pulse FSM, counter, pending-bit register.

Test Plan:
All stimulus uses 24-clk bits: a 0 is 18 low / 6 high, a 1 is 6 low / 18 high; stop bit is 6 low, then line held high.
- ID request 0x00 + stop -> 1 rx_start, 8 strobes with rx_data = 0, then rx_stop 30 clks after the stop bit's rising edge (+3 sync); no rx_error.
- Status request 0x400301 + stop -> 24 strobes, data MSB-first 0100_0000_0000_0011_0000_0001, then rx_stop.
- Threshold: low of 11 clks -> rx_data = 1; low of 12 clks -> rx_data = 0; both followed by a further bit so each strobe fires.
- Line held low 40 clks -> rx_error at low count 30, no strobe/stop. Then 30 high clks followed by frame 0x41 -> normal rx_start, 8 strobes, rx_stop.
- 0x00 followed by an 18-clk-low "stop" then idle -> 8 strobes, then rx_error, no rx_stop.
- Reset asserted after 3 bits -> all outputs 0 immediately. After release, next fall -> rx_start with no stale strobe.
